// File: rtl/sequenciador_comporta.sv
// Weighing-gate sequencer: validates each received weight frame and runs the
// servo through open / hold / close phases, with a manual open request.
module sequenciador_comporta #(
  parameter int T_MOVE   = 25000000,
  parameter int T_ABERTA = 100000000,
  parameter int CNT_W    = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       quadro_valido,
  input  logic [7:0] peso_max,
  input  logic [7:0] peso_min,
  input  logic [7:0] peso_atual,
  input  logic       abrir_manual,
  output logic       cmd_abrir,
  output logic       comporta_aberta,
  output logic       erro_quadro,
  output logic [7:0] aberturas,
  output logic [7:0] descartados,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ESPERA   = 4'd1,
    VALIDA   = 4'd2,
    COMPARA  = 4'd3,
    ABRINDO  = 4'd4,
    ABERTA   = 4'd5,
    FECHANDO = 4'd6,
    ERRO     = 4'd7
  } estado_t;

  localparam logic [CNT_W-1:0] FIM_MOVE   = CNT_W'(T_MOVE - 1);
  localparam logic [CNT_W-1:0] FIM_ABERTA = CNT_W'(T_ABERTA - 1);

  estado_t          estado;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       r_max, r_min, r_atual;
  logic             bcd_invalido, faixa_ok, ocupado;

  function automatic logic nibble_ruim(input logic [7:0] v);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

  assign bcd_invalido = nibble_ruim(r_max) || nibble_ruim(r_min) || nibble_ruim(r_atual);
  assign faixa_ok     = (r_atual >= r_min) && (r_atual <= r_max);
  assign ocupado      = (estado >= VALIDA) && (estado <= FECHANDO);

  // Moore outputs taken straight from the state register, so reset drops them at once
  assign cmd_abrir       = (estado == ABRINDO) || (estado == ABERTA);
  assign comporta_aberta = (estado == ABERTA);
  assign erro_quadro     = (estado == ERRO);
  assign db_estado       = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= INICIAL;
      cnt         <= '0;
      r_max       <= 8'h00;
      r_min       <= 8'h00;
      r_atual     <= 8'h00;
      aberturas   <= 8'h00;
      descartados <= 8'h00;
    end else begin
      if (ocupado && quadro_valido && (descartados != 8'hFF))
        descartados <= descartados + 8'd1;
      case (estado)
        INICIAL: estado <= ESPERA;
        ESPERA: begin
          if (quadro_valido) begin
            r_max   <= peso_max;
            r_min   <= peso_min;
            r_atual <= peso_atual;
            estado  <= VALIDA;
          end else if (abrir_manual) begin
            cnt    <= '0;
            estado <= ABRINDO;
          end
        end
        VALIDA: begin
          if (bcd_invalido || (r_min > r_max)) estado <= ERRO;
          else if (r_max == 8'h00)             estado <= ESPERA;
          else                                 estado <= COMPARA;
        end
        COMPARA: begin
          if (faixa_ok) begin
            cnt    <= '0;
            estado <= ABRINDO;
          end else begin
            estado <= ESPERA;
          end
        end
        ABRINDO: begin
          if (cnt == FIM_MOVE) begin
            cnt    <= '0;
            estado <= ABERTA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ABERTA: begin
          if (cnt == FIM_ABERTA) begin
            cnt    <= '0;
            estado <= FECHANDO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // a cycle only counts once the close travel has fully elapsed
        FECHANDO: begin
          if (cnt == FIM_MOVE) begin
            cnt    <= '0;
            estado <= ESPERA;
            if (aberturas != 8'hFF) aberturas <= aberturas + 8'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ERRO: begin
          if (quadro_valido) begin
            r_max   <= peso_max;
            r_min   <= peso_min;
            r_atual <= peso_atual;
            estado  <= VALIDA;
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule
